mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register for the LEGv8 pipeline. Consumes the EX/MEM register outputs, performs doubleword loads/stores against an internal data memory with configurable multi-cycle latency, stalls the front of the pipeline while an access is in flight, and registers results into the write-back stage. Also produces the write-back result used by the register file and the EX-stage forwarding muxes.

---
 rtl/mem_wb_stage.sv | 115 +++++++++++
 tb/tb_mem_wb_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// LEGv8 memory-access stage with MEM/WB pipeline register.
// Doubleword data memory with MEM_LATENCY-cycle accesses; stalls upstream while an access is in flight.
module mem_wb_stage #(
    parameter int ADDR_BITS   = 7,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ALUResult_M,
    input  logic [63:0] ReadData2_M,
    input  logic        RegWrite_M,
    input  logic        MemWrite_M,
    input  logic        MemToReg_M,
    input  logic        MemRead_M,
    input  logic [4:0]  DestinationReg_M,
    output logic        Stall_M,
    output logic        RegWrite_W,
    output logic        MemToReg_W,
    output logic [4:0]  DestinationReg_W,
    output logic [63:0] ALUResult_W,
    output logic [63:0] ReadData_W,
    output logic        AddrError_W,
    output logic [63:0] Result_W
);

    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [2:0] LAST  = 3'(MEM_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        memop, aligned, access, misaligned;
    logic [ADDR_BITS-1:0] index;
    logic [63:0] mem [DEPTH];
    logic [63:0] memWord;

    logic        regWrite_q, regWrite_d;
    logic        memToReg_q, memToReg_d;
    logic [4:0]  dest_q, dest_d;
    logic [63:0] aluResult_q, aluResult_d;
    logic [63:0] readData_q, readData_d;
    logic        addrError_q, addrError_d;

    assign memop      = MemRead_M | MemWrite_M;
    assign aligned    = (ALUResult_M[2:0] == 3'b000);
    assign access     = memop & aligned;
    assign misaligned = memop & ~aligned;
    assign index      = ALUResult_M[ADDR_BITS+2:3];
    assign memWord    = mem[index];

    // In IDLE the counter is zero, so a fresh access stalls unless it finishes in one cycle.
    assign Stall_M = access & ((state_q == IDLE) ? (LAST != 3'd0) : (cnt_q != LAST));

    always_comb begin
        cnt_d       = 3'd0;
        state_d     = IDLE;
        regWrite_d  = 1'b0;
        memToReg_d  = 1'b0;
        dest_d      = 5'd0;
        aluResult_d = 64'd0;
        readData_d  = 64'd0;
        addrError_d = 1'b0;
        if (Stall_M) begin
            cnt_d   = cnt_q + 3'd1;
            state_d = BUSY;
        end else begin
            regWrite_d  = RegWrite_M & ~misaligned;
            memToReg_d  = MemToReg_M;
            dest_d      = DestinationReg_M;
            aluResult_d = ALUResult_M;
            readData_d  = (access & MemRead_M) ? memWord : 64'd0;
            addrError_d = misaligned;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            regWrite_q  <= 1'b0;
            memToReg_q  <= 1'b0;
            dest_q      <= 5'd0;
            aluResult_q <= 64'd0;
            readData_q  <= 64'd0;
            addrError_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regWrite_q  <= regWrite_d;
            memToReg_q  <= memToReg_d;
            dest_q      <= dest_d;
            aluResult_q <= aluResult_d;
            readData_q  <= readData_d;
            addrError_q <= addrError_d;
        end
    end

    // Array is never reset; a store commits only on its completing edge, never while reset is held.
    always_ff @(posedge clk) begin
        if (reset && access && MemWrite_M && !Stall_M) begin
            mem[index] <= ReadData2_M;
        end
    end

    assign RegWrite_W       = regWrite_q;
    assign MemToReg_W       = memToReg_q;
    assign DestinationReg_W = dest_q;
    assign ALUResult_W      = aluResult_q;
    assign ReadData_W       = readData_q;
    assign AddrError_W      = addrError_q;
    assign Result_W         = memToReg_q ? readData_q : aluResult_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized ops against a behavioural
// model (word array plus expected WB values), checked every cycle on the falling edge.
module tb_mem_wb_stage;

   localparam int ADDR_BITS = 7;
   localparam int LAT       = 2;
   localparam int DEPTH     = 1 << ADDR_BITS;

   logic        clk;
   logic        reset;
   logic [63:0] ALUResult_M, ReadData2_M;
   logic        RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M;
   logic [4:0]  DestinationReg_M;
   logic        Stall_M, RegWrite_W, MemToReg_W, AddrError_W;
   logic [4:0]  DestinationReg_W;
   logic [63:0] ALUResult_W, ReadData_W, Result_W;

   logic        stall1, regWrite1, memToReg1, addrError1;
   logic [4:0]  dest1;
   logic [63:0] aluResult1, readData1, result1;

   mem_wb_stage #(.ADDR_BITS(ADDR_BITS), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .ALUResult_M(ALUResult_M), .ReadData2_M(ReadData2_M),
      .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
      .MemToReg_M(MemToReg_M), .MemRead_M(MemRead_M),
      .DestinationReg_M(DestinationReg_M),
      .Stall_M(Stall_M), .RegWrite_W(RegWrite_W), .MemToReg_W(MemToReg_W),
      .DestinationReg_W(DestinationReg_W), .ALUResult_W(ALUResult_W),
      .ReadData_W(ReadData_W), .AddrError_W(AddrError_W), .Result_W(Result_W)
   );

   // Single-cycle instance sharing the same stimulus; it must never stall.
   mem_wb_stage #(.ADDR_BITS(ADDR_BITS), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .ALUResult_M(ALUResult_M), .ReadData2_M(ReadData2_M),
      .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
      .MemToReg_M(MemToReg_M), .MemRead_M(MemRead_M),
      .DestinationReg_M(DestinationReg_M),
      .Stall_M(stall1), .RegWrite_W(regWrite1), .MemToReg_W(memToReg1),
      .DestinationReg_W(dest1), .ALUResult_W(aluResult1),
      .ReadData_W(readData1), .AddrError_W(addrError1), .Result_W(result1)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          checks = 0;
   int          errors = 0;
   int          stallCount = 0;
   bit          checkEn = 1'b0;

   logic [63:0] modelMem [DEPTH];
   logic        eStall, eRegWrite, eMemToReg, eAddrError;
   logic [4:0]  eDest;
   logic [63:0] eAlu, eReadData;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic setBubble();
      eRegWrite  = 1'b0;
      eMemToReg  = 1'b0;
      eDest      = 5'd0;
      eAlu       = 64'd0;
      eReadData  = 64'd0;
      eAddrError = 1'b0;
   endtask

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("Stall_M", 64'(Stall_M), 64'(eStall));
         checkOutput("RegWrite_W", 64'(RegWrite_W), 64'(eRegWrite));
         checkOutput("MemToReg_W", 64'(MemToReg_W), 64'(eMemToReg));
         checkOutput("DestinationReg_W", 64'(DestinationReg_W), 64'(eDest));
         checkOutput("ALUResult_W", ALUResult_W, eAlu);
         checkOutput("ReadData_W", ReadData_W, eReadData);
         checkOutput("AddrError_W", 64'(AddrError_W), 64'(eAddrError));
         checkOutput("Result_W", Result_W, eMemToReg ? eReadData : eAlu);
         checkOutput("Stall_M_lat1", 64'(stall1), 64'd0);
         if (Stall_M) stallCount++;
      end
   end

   task automatic driveInputs(input logic [63:0] alu, input logic [63:0] data,
                              input logic rd, input logic wr, input logic mtr,
                              input logic rw, input logic [4:0] dest);
      ALUResult_M      = alu;
      ReadData2_M      = data;
      MemRead_M        = rd;
      MemWrite_M       = wr;
      MemToReg_M       = mtr;
      RegWrite_M       = rw;
      DestinationReg_M = dest;
   endtask

   // Present one op, update the model, and hold it until it completes.
   task automatic applyStimulus(input logic [63:0] alu, input logic [63:0] data,
                                input logic rd, input logic wr, input logic mtr,
                                input logic rw, input logic [4:0] dest);
      bit          isMem, isAligned;
      int          idx, cycles;
      logic [63:0] rdVal;
      isMem     = rd | wr;
      isAligned = (alu % 8) == 0;
      idx       = int'((alu / 8) % DEPTH);
      rdVal     = 64'd0;
      if (isMem && isAligned) begin
         if (rd) rdVal = modelMem[idx];
         if (wr) modelMem[idx] = data;
      end
      cycles     = (isMem && isAligned) ? LAT : 1;
      stallCount = 0;
      driveInputs(alu, data, rd, wr, mtr, rw, dest);
      for (int k = 0; k < cycles; k++) begin
         eStall = (k < cycles - 1);
         @(posedge clk);
         #1;
         if (k < cycles - 1) begin
            setBubble();
         end else begin
            eRegWrite  = rw & ~(isMem & ~isAligned);
            eMemToReg  = mtr;
            eDest      = dest;
            eAlu       = alu;
            eReadData  = rdVal;
            eAddrError = isMem & ~isAligned;
         end
      end
      eStall = 1'b0;
   endtask

   task automatic applyNop();
      applyStimulus(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   initial begin
      logic [63:0] alu, data;
      logic        rd, wr;
      int          kind, sel;

      driveInputs(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      setBubble();
      eStall = 1'b0;
      reset  = 1'b1;
      #2 reset = 1'b0;
      #20 reset = 1'b1;
      checkEn = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < DEPTH; i++)
         applyStimulus(64'(i * 8), {32'(i), 32'hC0DE0000 + 32'(i)}, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);

      // Store then load 0x40: one stall cycle each, load returns the stored word.
      applyStimulus(64'h40, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      checkOutput("store_stall_cycles", 64'(stallCount), 64'd1);
      applyStimulus(64'h40, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
      checkOutput("load_stall_cycles", 64'(stallCount), 64'd1);
      checkOutput("load_ReadData_W", ReadData_W, 64'hDEADBEEFCAFEF00D);
      checkOutput("load_Result_W", Result_W, 64'hDEADBEEFCAFEF00D);
      checkOutput("load_RegWrite_W", 64'(RegWrite_W), 64'd1);
      checkOutput("load_Dest_W", 64'(DestinationReg_W), 64'd5);

      // Plain ALU op passes straight through.
      applyStimulus(64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
      checkOutput("alu_stall_cycles", 64'(stallCount), 64'd0);
      checkOutput("alu_ALUResult_W", ALUResult_W, 64'h1234);
      checkOutput("alu_Result_W", Result_W, 64'h1234);
      checkOutput("alu_Dest_W", 64'(DestinationReg_W), 64'd9);

      // Misaligned accesses flag an error and leave memory alone.
      applyStimulus(64'h43, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
      checkOutput("mis_stall_cycles", 64'(stallCount), 64'd0);
      checkOutput("mis_AddrError_W", 64'(AddrError_W), 64'd1);
      checkOutput("mis_RegWrite_W", 64'(RegWrite_W), 64'd0);
      applyStimulus(64'h43, 64'h0BADBADBADBADBAD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      applyStimulus(64'h40, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1);
      checkOutput("mis_word8_kept", ReadData_W, 64'hDEADBEEFCAFEF00D);

      // Reset in the middle of a store aborts it.
      applyStimulus(64'h80, 64'h11, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      driveInputs(64'h80, 64'h55, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      eStall = 1'b1;
      @(posedge clk);
      #1;
      setBubble();
      eStall = 1'b0;
      driveInputs(64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      reset = 1'b0;
      #1;
      checkOutput("rst_Stall_M", 64'(Stall_M), 64'd0);
      checkOutput("rst_RegWrite_W", 64'(RegWrite_W), 64'd0);
      checkOutput("rst_Dest_W", 64'(DestinationReg_W), 64'd0);
      checkOutput("rst_ALUResult_W", ALUResult_W, 64'd0);
      checkOutput("rst_ReadData_W", ReadData_W, 64'd0);
      checkOutput("rst_Result_W", Result_W, 64'd0);
      @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      applyStimulus(64'h80, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
      checkOutput("abort_load_80", ReadData_W, 64'h11);

      // Addresses wrap modulo the memory depth.
      applyStimulus(64'h400, 64'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      applyStimulus(64'h0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
      checkOutput("wrap_load_0", ReadData_W, 64'hA5);

      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 9);
         sel  = $urandom_range(0, 2);
         rd   = (sel != 1);
         wr   = (sel != 0);
         data = {$urandom, $urandom};
         if (kind < 5) begin
            alu = 64'($urandom_range(0, 4 * DEPTH - 1)) << 3;
         end else if (kind < 7) begin
            alu = (64'($urandom_range(0, 4 * DEPTH - 1)) << 3) | 64'($urandom_range(1, 7));
         end else begin
            alu = {$urandom, $urandom};
            rd  = 1'b0;
            wr  = 1'b0;
         end
         applyStimulus(alu, data, rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)));
      end
      applyNop();

      checkEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
